// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver presenting make codes with a 1-cycle valid strobe.
// Define PS2_BREAK_REPORT_EN to also report F0-prefixed break codes on key_release.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic [7:0] keyboard,
  output logic       valid,
  output logic       extended,
`ifdef PS2_BREAK_REPORT_EN
  output logic       key_release,
`endif
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] kc_q, kd_q;
  logic kc_prev_q;
  logic [7:0] sr_q, sr_d, kb_q, kb_d;
  logic [2:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic valid_q, valid_d, xt_q, xt_d, err_q, err_d;
  logic fall, din, timeout;
`ifdef PS2_BREAK_REPORT_EN
  logic rel_q, rel_d;
  assign key_release = rel_q;
`endif
  assign fall     = kc_prev_q & ~kc_q[SYNC_STAGES-1];
  assign din      = kd_q[SYNC_STAGES-1];
  assign timeout  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign keyboard = kb_q;
  assign valid    = valid_q;
  assign extended = xt_q;
  assign frame_err = err_q;
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    kb_d    = kb_q;
    xt_d    = xt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef PS2_BREAK_REPORT_EN
    rel_d   = rel_q;
`endif
    tmo_d   = (state_q == IDLE || fall || timeout) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      // a stalled partial frame wins over an edge landing in the same cycle
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          err_d   = din;
          state_d = din ? IDLE : SHIFT;
          cnt_d   = 3'd0;
        end
        SHIFT: begin
          sr_d    = {din, sr_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? PARITY : SHIFT;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!din || !(^sr_q ^ par_q)) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (sr_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (sr_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
`ifdef PS2_BREAK_REPORT_EN
            valid_d = 1'b1;
            kb_d    = sr_q;
            xt_d    = ext_q;
            rel_d   = brk_q;
`else
            valid_d = !brk_q;
            kb_d    = brk_q ? kb_q : sr_q;
            xt_d    = brk_q ? xt_q : ext_q;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kc_q      <= '1;
      kd_q      <= '1;
      kc_prev_q <= 1'b1;
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      kb_q      <= '0;
      xt_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_BREAK_REPORT_EN
      rel_q     <= 1'b0;
`endif
    end else begin
      kc_q      <= {kc_q[SYNC_STAGES-2:0], key_clk};
      kd_q      <= {kd_q[SYNC_STAGES-2:0], key_data};
      kc_prev_q <= kc_q[SYNC_STAGES-1];
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      kb_q      <= kb_d;
      xt_q      <= xt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef PS2_BREAK_REPORT_EN
      rel_q     <= rel_d;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven, hand-sequenced and randomized checks of the PS/2 receiver.
module tb_ps2_scancode_rx;
  localparam int TO   = 100;
  localparam int HALF = 8;
  localparam int LAT  = 3;
`ifdef PS2_BREAK_REPORT_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif
  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         stop;
    int         nv;
    logic [7:0] kb;
    bit         x;
    bit         r;
    int         ne;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, key_clk = 1'b1, key_data = 1'b1;
  logic [7:0] keyboard;
  logic valid, extended, frame_err, key_release;
  int cyc = 0, ecnt = 0, both = 0, vcyc = 0, ecyc = 0, fall_cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic [9:0] vq[$];
  vec_t tbl[18];
  ps2_scancode_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .key_clk(key_clk), .key_data(key_data),
    .keyboard(keyboard), .valid(valid), .extended(extended),
`ifdef PS2_BREAK_REPORT_EN
    .key_release(key_release),
`endif
    .frame_err(frame_err)
  );
`ifndef PS2_BREAK_REPORT_EN
  assign key_release = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back({key_release, extended, keyboard});
      vcyc = cyc;
    end
    if (frame_err) begin
      ecnt++;
      ecyc = cyc;
    end
    if (valid && frame_err) both++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    key_data = b;
    repeat (HALF/2) @(negedge clk);
    key_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    key_clk = 1'b1;
    repeat (HALF/2) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ flip);
    send_bit(stop);
    repeat (6) @(negedge clk);
  endtask
  task automatic check_frame(input string nm, input int nv, input logic [7:0] kb, input bit x,
                             input bit r, input int ne);
    chk({nm, "_valid_count"}, vq.size(), nv);
    chk({nm, "_err_count"}, ecnt, ne);
    chk({nm, "_keyboard"}, keyboard, kb);
    chk({nm, "_extended"}, extended, x);
    if (BRK) chk({nm, "_release"}, key_release, r);
    if (vq.size() > 0) chk({nm, "_latency"}, vcyc - fall_cyc, LAT);
    vq.delete();
    ecnt = 0;
  endtask
  initial begin
    logic [7:0] m_kb, b;
    bit m_x, m_r, m_ext, m_brk, bad;
    int nv, ne, d;
    tbl = '{
      '{8'h16, 0, 1, 1, 8'h16, 0, 0, 0},
      '{8'hE0, 0, 1, 0, 8'h16, 0, 0, 0},
      '{8'h75, 0, 1, 1, 8'h75, 1, 0, 0},
      '{8'h1E, 0, 1, 1, 8'h1E, 0, 0, 0},
      '{8'hF0, 0, 1, 0, 8'h1E, 0, 0, 0},
      '{8'h1E, 0, 1, BRK ? 1 : 0, 8'h1E, 0, BRK, 0},
      '{8'h5A, 1, 1, 0, 8'h1E, 0, BRK, 1},
      '{8'h5A, 0, 1, 1, 8'h5A, 0, 0, 0},
      '{8'h5A, 0, 0, 0, 8'h5A, 0, 0, 1},
      '{8'hE0, 0, 1, 0, 8'h5A, 0, 0, 0},
      '{8'hF0, 0, 1, 0, 8'h5A, 0, 0, 0},
      '{8'h12, 0, 1, BRK ? 1 : 0, BRK ? 8'h12 : 8'h5A, BRK, BRK, 0},
      '{8'h12, 0, 1, 1, 8'h12, 0, 0, 0},
      '{8'hE0, 0, 1, 0, 8'h12, 0, 0, 0},
      '{8'h33, 1, 1, 0, 8'h12, 0, 0, 1},
      '{8'h75, 0, 1, 1, 8'h75, 0, 0, 0},
      '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0},
      '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0}
    };
    repeat (3) @(negedge clk);
    chk("reset_keyboard", keyboard, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_extended", extended, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      send_frame(tbl[i].b, tbl[i].flip, tbl[i].stop);
      check_frame($sformatf("row%0d", i), tbl[i].nv, tbl[i].kb, tbl[i].x, tbl[i].r, tbl[i].ne);
    end
    m_kb = 8'h1C; m_x = 0; m_r = 0; m_ext = 0; m_brk = 0;
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 9));
      bad = (d == 4);
      if (d < 2) b = 8'hE0;
      else if (d < 4) b = 8'hF0;
      else begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
      end
      nv = 0; ne = 0;
      if (bad) begin
        ne = 1; m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (!m_brk || BRK) begin
          nv = 1; m_kb = b; m_x = m_ext; m_r = m_brk;
        end
        m_ext = 0; m_brk = 0;
      end
      send_frame(b, bad, 1'b1);
      check_frame($sformatf("rnd%0d", n), nv, m_kb, m_x, m_r, ne);
    end
    if (m_ext || m_brk) begin
      send_frame(8'h29, 1'b0, 1'b1);
      check_frame("rnd_flush", (m_brk && !BRK) ? 0 : 1, (m_brk && !BRK) ? m_kb : 8'h29,
                  m_ext, m_brk, 0);
      m_kb = (m_brk && !BRK) ? m_kb : 8'h29;
    end
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TO + 20) @(negedge clk);
    d = ecyc - fall_cyc;
    chk("timeout_err_count", ecnt, 1);
    chk("timeout_no_valid", vq.size(), 0);
    chk("timeout_window", (d >= TO && d <= TO + 5), 1'b1);
    ecnt = 0;
    send_frame(8'h26, 1'b0, 1'b1);
    check_frame("after_timeout", 1, 8'h26, 0, 0, 0);
    b = 8'h25;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    #2 rst = 1'b0;
    #1;
    chk("midreset_keyboard", keyboard, 8'h00);
    chk("midreset_valid", valid, 1'b0);
    chk("midreset_extended", extended, 1'b0);
    chk("midreset_frame_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    vq.delete();
    ecnt = 0;
    send_frame(8'h25, 1'b0, 1'b1);
    check_frame("after_reset", 1, 8'h25, 0, 0, 0);
    chk("valid_err_overlap", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
